// File: rtl/calendar.sv
// Date counter (day/month/year/day-of-week) driven by the midnight rollover
// of the upstream hh:mm:ss block; BCD digits for the date display.
module calendar #(
   parameter int unsigned LEAP_EN = 1,
   parameter int unsigned DOW_MAX = 6
) (
   input  logic        clk_1hz,
   input  logic        time_ow,
   input  logic [18:0] date_in,
   input  logic [4:0]  hour_in,
   output logic        day_tick,
   output logic        year_wrap,
   output logic [2:0]  dow_out,
   output logic [3:0]  day_1s,
   output logic [3:0]  day_10s,
   output logic [3:0]  mon_1s,
   output logic [3:0]  mon_10s,
   output logic [3:0]  yr_1s,
   output logic [3:0]  yr_10s
);

   localparam logic [2:0] DOW_LAST = 3'(DOW_MAX);

   logic [6:0] yy_q, yy_d;
   logic [3:0] mon_q, mon_d;
   logic [4:0] day_q, day_d;
   logic [2:0] dow_q, dow_d;
   logic [4:0] hour_q;
   logic       tick_q, tick_d;
   logic       wrap_q, wrap_d;

   logic [6:0] ld_yy;
   logic [3:0] ld_mon;
   logic [4:0] ld_day, ld_dim;
   logic [2:0] ld_dow;
   logic [4:0] cur_dim;
   logic       adv;

   function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [6:0] y);
      logic [4:0] d;
      case (m)
         4'd2:                     d = (LEAP_EN != 0 && y[1:0] == 2'b00) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:  d = 5'd30;
         default:                  d = 5'd31;
      endcase
      return d;
   endfunction

   function automatic logic [7:0] bcd_f(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   // Load sanitization: the day clamp uses the already-sanitized month and year.
   always_comb begin
      ld_yy  = (date_in[18:12] > 7'd99) ? 7'd99 : date_in[18:12];
      ld_mon = date_in[11:8];
      if (ld_mon == 4'd0)
         ld_mon = 4'd1;
      else if (ld_mon > 4'd12)
         ld_mon = 4'd12;
      ld_dim = dim_f(ld_mon, ld_yy);
      ld_day = date_in[7:3];
      if (ld_day == 5'd0)
         ld_day = 5'd1;
      else if (ld_day > ld_dim)
         ld_day = ld_dim;
      ld_dow = (date_in[2:0] > DOW_LAST) ? 3'd0 : date_in[2:0];
   end

   always_comb begin
      yy_d    = yy_q;
      mon_d   = mon_q;
      day_d   = day_q;
      dow_d   = dow_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      cur_dim = dim_f(mon_q, yy_q);
      adv     = (hour_q == 5'd23) && (hour_in == 5'd0);
      if (adv) begin
         tick_d = 1'b1;
         dow_d  = (dow_q >= DOW_LAST) ? 3'd0 : dow_q + 3'd1;
         if (day_q < cur_dim) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d = 5'd1;
            if (mon_q < 4'd12) begin
               mon_d = mon_q + 4'd1;
            end else begin
               mon_d = 4'd1;
               if (yy_q >= 7'd99) begin
                  yy_d   = 7'd0;
                  wrap_d = 1'b1;
               end else begin
                  yy_d = yy_q + 7'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_1hz or posedge time_ow) begin
      if (time_ow) begin
         yy_q   <= ld_yy;
         mon_q  <= ld_mon;
         day_q  <= ld_day;
         dow_q  <= ld_dow;
         hour_q <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         yy_q   <= yy_d;
         mon_q  <= mon_d;
         day_q  <= day_d;
         dow_q  <= dow_d;
         hour_q <= hour_in;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign day_tick          = tick_q;
   assign year_wrap         = wrap_q;
   assign dow_out           = dow_q;
   assign {day_10s, day_1s} = bcd_f({2'b00, day_q});
   assign {mon_10s, mon_1s} = bcd_f({3'b000, mon_q});
   assign {yr_10s, yr_1s}   = bcd_f(yy_q);

endmodule

// File: tb/tb_calendar.sv
// Scoreboard bench for calendar: expectations queued with the stimulus,
// popped and compared at the following negedge.
module tb_calendar;

   logic        clk = 1'b0;
   logic        time_ow = 1'b0;
   logic [18:0] date_in = '0;
   logic [4:0]  hour_in = '0;

   logic       a_tick, a_wrap, b_tick, b_wrap;
   logic [2:0] a_dow, b_dow;
   logic [3:0] a_d1, a_d10, a_m1, a_m10, a_y1, a_y10;
   logic [3:0] b_d1, b_d10, b_m1, b_m10, b_y1, b_y10;

   calendar dut (
      .clk_1hz(clk), .time_ow(time_ow), .date_in(date_in), .hour_in(hour_in),
      .day_tick(a_tick), .year_wrap(a_wrap), .dow_out(a_dow),
      .day_1s(a_d1), .day_10s(a_d10), .mon_1s(a_m1), .mon_10s(a_m10),
      .yr_1s(a_y1), .yr_10s(a_y10)
   );

   calendar #(.LEAP_EN(0), .DOW_MAX(6)) dut_nl (
      .clk_1hz(clk), .time_ow(time_ow), .date_in(date_in), .hour_in(hour_in),
      .day_tick(b_tick), .year_wrap(b_wrap), .dow_out(b_dow),
      .day_1s(b_d1), .day_10s(b_d10), .mon_1s(b_m1), .mon_10s(b_m10),
      .yr_1s(b_y1), .yr_10s(b_y10)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [28:0] v;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests = 0;
   int   failed = 0;

   function automatic logic [28:0] ev(int yy, int mon, int day, int dow, bit tk, bit wr);
      return {4'(day / 10), 4'(day % 10), 4'(mon / 10), 4'(mon % 10),
              4'(yy / 10), 4'(yy % 10), 3'(dow), tk, wr};
   endfunction

   function automatic logic [28:0] obs_a();
      return {a_d10, a_d1, a_m10, a_m1, a_y10, a_y1, a_dow, a_tick, a_wrap};
   endfunction

   function automatic logic [28:0] obs_b();
      return {b_d10, b_d1, b_m10, b_m1, b_y10, b_y1, b_dow, b_tick, b_wrap};
   endfunction

   function automatic void push(string n, logic [28:0] v);
      exp_t x;
      x.name = n;
      x.v    = v;
      sb.push_back(x);
   endfunction

   // Called at a negedge; returns at the next negedge after one active edge.
   task automatic hour_step(input logic [4:0] h);
      hour_in = h;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input int yy, input int mon, input int day, input int dow);
      @(negedge clk);
      date_in = {7'(yy), 4'(mon), 5'(day), 3'(dow)};
      hour_in = 5'd0;
      time_ow = 1'b1;
      #2;
      @(negedge clk);
      time_ow = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      date_in = {7'd24, 4'd2, 5'd28, 3'd2};
      hour_in = 5'd0;
      time_ow = 1'b1;
      #1;
      push("reset_held", ev(24, 2, 28, 2, 0, 0));
      e = sb.pop_front(); tests++;
      if (obs_a() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
      end
      @(negedge clk);
      time_ow = 1'b0;
      push("reset_release", ev(24, 2, 28, 2, 0, 0));
      hour_step(5'd0);
      e = sb.pop_front(); tests++;
      if (obs_a() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
      end
   endtask

   task automatic test_leap_day();
      load(24, 2, 28, 2);
      push("leap_h23", ev(24, 2, 28, 2, 0, 0));
      push("leap_adv", ev(24, 2, 29, 3, 1, 0));
      push("leap_after", ev(24, 2, 29, 3, 0, 0));
      hour_step(5'd23);
      e = sb.pop_front(); tests++;
      if (obs_a() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
      end
      for (int i = 0; i < 2; i++) begin
         hour_step(5'd0);
         e = sb.pop_front(); tests++;
         if (obs_a() !== e.v) begin
            failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
         end
      end
   endtask

   task automatic test_month_roll();
      load(23, 2, 28, 6);
      push("feb_nonleap", ev(23, 3, 1, 0, 1, 0));
      hour_step(5'd23);
      hour_step(5'd0);
      e = sb.pop_front(); tests++;
      if (obs_a() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
      end
      load(24, 2, 28, 1);
      push("leap_disabled", ev(24, 3, 1, 2, 1, 0));
      hour_step(5'd23);
      hour_step(5'd0);
      e = sb.pop_front(); tests++;
      if (obs_b() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_b(), e.v);
      end
      load(24, 4, 30, 4);
      push("apr30_roll", ev(24, 5, 1, 5, 1, 0));
      hour_step(5'd23);
      hour_step(5'd0);
      e = sb.pop_front(); tests++;
      if (obs_a() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
      end
   endtask

   task automatic test_year_wrap();
      load(99, 12, 31, 6);
      push("wrap_adv", ev(0, 1, 1, 0, 1, 1));
      push("wrap_after", ev(0, 1, 1, 0, 0, 0));
      hour_step(5'd23);
      for (int i = 0; i < 2; i++) begin
         hour_step(5'd0);
         e = sb.pop_front(); tests++;
         if (obs_a() !== e.v) begin
            failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
         end
      end
   endtask

   task automatic test_clamp();
      int vals[5][4] = '{'{24, 4, 31, 1}, '{24, 0, 0, 1}, '{24, 15, 5, 1},
                         '{24, 5, 5, 7}, '{120, 2, 30, 3}};
      push("clamp_apr31", ev(24, 4, 30, 1, 0, 0));
      push("clamp_zero", ev(24, 1, 1, 1, 0, 0));
      push("clamp_mon15", ev(24, 12, 5, 1, 0, 0));
      push("clamp_dow7", ev(24, 5, 5, 0, 0, 0));
      push("clamp_yy120", ev(99, 2, 28, 3, 0, 0));
      for (int i = 0; i < 5; i++) begin
         load(vals[i][0], vals[i][1], vals[i][2], vals[i][3]);
         e = sb.pop_front(); tests++;
         if (obs_a() !== e.v) begin
            failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
         end
      end
   endtask

   task automatic test_glitch();
      logic [4:0] hs[8] = '{5'd5, 5'd0, 5'd23, 5'd23, 5'd0, 5'd0, 5'd0, 5'd0};
      load(24, 6, 10, 0);
      for (int i = 0; i < 8; i++)
         push($sformatf("glitch_%0d", i), (i < 4) ? ev(24, 6, 10, 0, 0, 0)
                                        : ev(24, 6, 11, 1, (i == 4), 0));
      for (int i = 0; i < 8; i++) begin
         hour_step(hs[i]);
         e = sb.pop_front(); tests++;
         if (obs_a() !== e.v) begin
            failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
         end
      end
   endtask

   task automatic test_ow_override();
      load(24, 3, 15, 4);
      hour_step(5'd23);
      date_in = {7'd30, 4'd8, 5'd20, 3'd1};
      hour_in = 5'd0;
      time_ow = 1'b1;
      push("ow_wins", ev(30, 8, 20, 1, 0, 0));
      push("ow_release", ev(30, 8, 20, 1, 0, 0));
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front(); tests++;
      if (obs_a() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
      end
      time_ow = 1'b0;
      hour_step(5'd0);
      e = sb.pop_front(); tests++;
      if (obs_a() !== e.v) begin
         failed++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_leap_day();
      test_month_roll();
      test_year_wrap();
      test_clamp();
      test_glitch();
      test_ow_override();
      if (sb.size() != 0) begin
         tests++; failed++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
